// File: rtl/delay_line_ctrl_pkg.sv
// rtl/delay_line_ctrl_pkg.sv - shared types and constants for the delay line controller
// Purpose: FSM state encoding and the minimum effective delay.
// Ports: none (package).
package delay_line_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // A requested delay of 0 is promoted to this value so a read never
   // targets the address being written in the same cycle.
   localparam int MIN_DELAY = 1;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// rtl/delay_line_ctrl_if.sv - RAM-side bus between the delay line controller and dualport_ram
// Purpose: bundles the RAM write/read port signals.
// Ports (via modports):
//   master (controller): drives wr_en, rd_en, wr_addr, rd_addr, ram_din; receives ram_dout
//   slave  (RAM side)  : receives the above; drives ram_dout (valid 1 cycle after rd_en)
interface delay_line_ctrl_if #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
) ();

   logic                     wr_en;
   logic                     rd_en;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0]    ram_din;
   logic [DATA_WIDTH-1:0]    ram_dout;

   modport master (
      output wr_en, rd_en, wr_addr, rd_addr, ram_din,
      input  ram_dout
   );

   modport slave (
      input  wr_en, rd_en, wr_addr, rd_addr, ram_din,
      output ram_dout
   );

endinterface

// File: rtl/dualport_ram.sv
// rtl/dualport_ram.sv - simple dual-port RAM, one write port and one registered read port
// Purpose: sample storage for the delay line.
// Ports:
//   clk            system clock
//   wr_en/wr_addr/din   write port, written at posedge
//   rd_en/rd_addr       read port; dout updates at the posedge where rd_en is high
//   dout           read data, held between reads
module dualport_ram #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic [DATA_WIDTH-1:0]    dout
);

   logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= din;
      end
      if (rd_en) begin
         dout <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/delay_line_ctrl.sv
// rtl/delay_line_ctrl.sv - circular delay line controller on top of dualport_ram
// Purpose: writes one sample per en strobe and returns the sample written
//          delay strobes earlier, two cycles after the strobe.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   en           sample strobe
//   delay        requested delay in strobes (0 behaves as 1)
//   din          input sample, qualified by en
//   ram          RAM bus (master side)
//   dout         delayed sample, held between updates
//   dout_valid   one-cycle pulse when dout is updated
module delay_line_ctrl
   import delay_line_ctrl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [ADDRESS_WIDTH-1:0] delay,
   input  logic [DATA_WIDTH-1:0]    din,
   delay_line_ctrl_if.master        ram,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid
);

   localparam logic [ADDRESS_WIDTH-1:0] MIN_D = ADDRESS_WIDTH'(MIN_DELAY);

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH-1:0] fill_cnt, fill_nxt;
   logic [ADDRESS_WIDTH-1:0] delay_q, delay_q_nxt;
   logic [ADDRESS_WIDTH-1:0] delay_eff;
   logic                     dchg;
   logic                     rd_pend;
   logic                     rd_en_c;

   assign delay_eff = (delay == '0) ? MIN_D : delay;
   assign dchg      = (delay_eff != delay_q);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic, including the fill counter and latched delay.
   // A write that makes the fill count reach the delay enters RUN, so the
   // very next strobe can already read the sample delay strobes back.
   always_comb begin
      state_nxt   = state;
      fill_nxt    = fill_cnt;
      delay_q_nxt = delay_q;
      case (state)
         IDLE: begin
            delay_q_nxt = delay_eff;
            if (en) begin
               fill_nxt  = MIN_D;
               state_nxt = (delay_eff == MIN_D) ? RUN : FILL;
            end
         end
         FILL, RUN: begin
            if (dchg) begin
               // Contents behind the new delay are not trusted: refill.
               delay_q_nxt = delay_eff;
               if (en) begin
                  fill_nxt  = MIN_D;
                  state_nxt = (delay_eff == MIN_D) ? RUN : FILL;
               end else begin
                  fill_nxt  = '0;
                  state_nxt = FILL;
               end
            end else if (state == FILL && en) begin
               if ((fill_cnt + 1'b1) >= delay_q) begin
                  fill_nxt  = delay_q;
                  state_nxt = RUN;
               end else begin
                  fill_nxt  = fill_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output logic: RAM port drive
   always_comb begin
      rd_en_c     = en & rst_n & (state == RUN) & ~dchg;
      ram.wr_en   = en & rst_n;
      ram.rd_en   = rd_en_c;
      ram.wr_addr = wr_ptr;
      ram.rd_addr = wr_ptr - delay_eff;   // wraps modulo the buffer depth
      ram.ram_din = din;
   end

   // Datapath: write pointer, fill tracking and the two-stage read return
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         delay_q    <= '0;
         rd_pend    <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         if (en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         fill_cnt   <= fill_nxt;
         delay_q    <= delay_q_nxt;
         rd_pend    <= rd_en_c;
         dout_valid <= rd_pend;
         if (rd_pend) begin
            dout <= ram.ram_dout;
         end
      end
   end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb/tb_delay_line_ctrl.sv - directed self-checking bench for delay_line_ctrl with dualport_ram
module tb_delay_line_ctrl;
   import delay_line_ctrl_pkg::*;

   localparam int AW = 9;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [AW-1:0] delay = '0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          dout_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   delay_line_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

   delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .delay      (delay),
      .din        (din),
      .ram        (ram_bus),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   dualport_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
      .clk     (clk),
      .wr_en   (ram_bus.wr_en),
      .rd_en   (ram_bus.rd_en),
      .wr_addr (ram_bus.wr_addr),
      .rd_addr (ram_bus.rd_addr),
      .din     (ram_bus.ram_din),
      .dout    (ram_bus.ram_dout)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change at negedge; outputs are observed 1 time unit later,
   // well away from the posedge that ends the cycle.
   task automatic drive(input logic r, input logic e, input int d, input int x);
      @(negedge clk);
      rst_n = r;
      en    = e;
      delay = d[AW-1:0];
      din   = x[DW-1:0];
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      int exp_dout;
      int j;
      logic exp_rd;
      logic exp_v;

      // ---- 1. reset and fill, delay=3
      drive(1'b0, 1'b1, 3, 55);
      chk("rst_wr_en", int'(ram_bus.wr_en), 0);
      chk("rst_rd_en", int'(ram_bus.rd_en), 0);
      drive(1'b0, 1'b0, 3, 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_dout_valid", int'(dout_valid), 0);
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 3, i);
         chk("t1_wr_addr", int'(ram_bus.wr_addr), i);
         chk("t1_rd_en", int'(ram_bus.rd_en), int'(i >= 3));
         if (i >= 3) chk("t1_rd_addr", int'(ram_bus.rd_addr), i - 3);
         chk("t1_dout_valid", int'(dout_valid), int'(i >= 5));
         if (i >= 5) chk("t1_dout", int'(dout), i - 5);
      end

      // ---- 2. wrap-around, delay=5, 520 strobes
      do_reset();
      for (int i = 0; i < 520; i++) begin
         drive(1'b1, 1'b1, 5, i & 255);
         chk("t2_wr_addr", int'(ram_bus.wr_addr), i % 512);
         chk("t2_rd_en", int'(ram_bus.rd_en), int'(i >= 5));
         if (i >= 5) chk("t2_rd_addr", int'(ram_bus.rd_addr), (i - 5) % 512);
         chk("t2_dout_valid", int'(dout_valid), int'(i >= 7));
         if (i >= 7) chk("t2_dout", int'(dout), (i - 7) & 255);
         if (i == 514) begin
            chk("t2_wrap_wr_addr", int'(ram_bus.wr_addr), 2);
            chk("t2_wrap_rd_addr", int'(ram_bus.rd_addr), 509);
         end
      end

      // ---- 3. sparse strobes, delay=2, every 4th cycle
      do_reset();
      for (int c = 0; c < 18; c++) begin
         if ((c % 4 == 0) && (c <= 12)) drive(1'b1, 1'b1, 2, 10 * (c / 4 + 1));
         else                           drive(1'b1, 1'b0, 2, 8'hEE);
         chk("t3_rd_en", int'(ram_bus.rd_en), int'(c == 8 || c == 12));
         chk("t3_dout_valid", int'(dout_valid), int'(c == 10 || c == 14));
         chk("t3_dout", int'(dout), (c < 10) ? 0 : ((c < 14) ? 10 : 20));
      end

      // ---- 4. delay change 3 -> 6 while in RUN
      do_reset();
      exp_dout = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, (i < 8) ? 3 : 6, i);
         exp_rd = ((i >= 3) && (i <= 7)) || (i >= 14);
         chk("t4_rd_en", int'(ram_bus.rd_en), int'(exp_rd));
         if (exp_rd) chk("t4_rd_addr", int'(ram_bus.rd_addr), (i < 8) ? i - 3 : i - 6);
         j = i - 2;
         exp_v = (j >= 3) && ((j <= 7) || (j >= 14));
         if (exp_v) exp_dout = (j < 8) ? j - 3 : j - 6;
         chk("t4_dout_valid", int'(dout_valid), int'(exp_v));
         chk("t4_dout", int'(dout), exp_dout);
      end

      // ---- 5. delay=0 behaves as delay=1
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 0, 40 + i);
         chk("t5_rd_en", int'(ram_bus.rd_en), int'(i >= 1));
         if (i >= 1) chk("t5_rd_addr", int'(ram_bus.rd_addr), i - 1);
         chk("t5_dout_valid", int'(dout_valid), int'(i >= 3));
         if (i >= 3) chk("t5_dout", int'(dout), 40 + i - 3);
      end

      // ---- 6. reset right after a strobe in RUN, delay=2
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 2, i);
         chk("t6_rd_en", int'(ram_bus.rd_en), int'(i >= 2));
      end
      drive(1'b0, 1'b0, 2, 0);
      chk("t6_prev_read_valid", int'(dout_valid), 1);
      chk("t6_prev_read_dout", int'(dout), 2);
      chk("t6_rst_rd_en", int'(ram_bus.rd_en), 0);
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b1, 2, 100 + k);
         if (k == 0) begin
            chk("t6_dropped_valid", int'(dout_valid), 0);
            chk("t6_dropped_dout", int'(dout), 0);
         end
         chk("t6_post_wr_addr", int'(ram_bus.wr_addr), k);
         chk("t6_post_rd_en", int'(ram_bus.rd_en), int'(k >= 2));
         if (k >= 2) chk("t6_post_rd_addr", int'(ram_bus.rd_addr), k - 2);
         chk("t6_post_valid", int'(dout_valid), int'(k >= 4));
         if (k >= 4) chk("t6_post_dout", int'(dout), 100 + k - 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
